// File: rtl/alu_pkg.sv
// Shared opcode, FSM-state and iterative-unit mode encodings for the multi-cycle ALU.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'b0001,
        OP_SUB = 4'b0010,
        OP_MUL = 4'b0011,
        OP_DIV = 4'b0100,
        OP_MOD = 4'b0101,
        OP_AND = 4'b0110,
        OP_OR  = 4'b0111,
        OP_XOR = 4'b1000,
        OP_SHL = 4'b1001,
        OP_SHR = 4'b1010
    } op_t;

    localparam logic [3:0] OP_NONE = 4'b0000;

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    typedef enum logic {MD_MUL = 1'b0, MD_DIV = 1'b1} md_mode_t;

endpackage

// File: rtl/alu_multiciclo_if.sv
// Request/result bundle of the multi-cycle ALU; master issues operations, slave computes.
interface alu_multiciclo_if #(parameter int WIDTH = 4);
    logic                 start;
    logic [3:0]           op;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic                 Cin;
    logic                 ready;
    logic                 done;
    logic [WIDTH-1:0]     S;
    logic [2*WIDTH-1:0]   res;
    logic                 Z, N, V, C;
    logic                 err;

    modport master (output start, op, A, B, Cin,
                    input  ready, done, S, res, Z, N, V, C, err);
    modport slave  (input  start, op, A, B, Cin,
                    output ready, done, S, res, Z, N, V, C, err);
endinterface

// File: rtl/alu_muldiv_iter.sv
// Shift-add multiplier / restoring divider, one step per enabled cycle; the load edge applies step 1.
// No backpressure: the owner sequences load and WIDTH-1 further steps; {hi,lo} = product or {rem,quot}.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  md_mode_t         mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             step,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, d_q, d_d;
    md_mode_t         mode_q, mode_d;
    logic [WIDTH-1:0] src_hi, src_lo, src_d;
    md_mode_t         src_mode;
    logic [WIDTH:0]   acc, rem_sh, diff;

    always_comb begin
        src_mode = load ? mode : mode_q;
        src_hi   = load ? '0   : hi_q;
        src_lo   = load ? a    : lo_q;
        src_d    = load ? b    : d_q;
        acc      = {1'b0, src_hi} + (src_lo[0] ? {1'b0, src_d} : '0);
        rem_sh   = {src_hi, src_lo[WIDTH-1]};
        // rem < divisor always holds, so diff[WIDTH] is an exact borrow flag
        diff     = rem_sh - {1'b0, src_d};
        hi_d     = hi_q;
        lo_d     = lo_q;
        d_d      = src_d;
        mode_d   = src_mode;
        if (load || step) begin
            if (src_mode == MD_MUL) begin
                {hi_d, lo_d} = {acc, src_lo[WIDTH-1:1]};
            end else if (!diff[WIDTH]) begin
                hi_d = diff[WIDTH-1:0];
                lo_d = {src_lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = rem_sh[WIDTH-1:0];
                lo_d = {src_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_q   <= '0;
            lo_q   <= '0;
            d_q    <= '0;
            mode_q <= MD_MUL;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            d_q    <= d_d;
            mode_q <= mode_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: rtl/alu_multiciclo.sv
// Registered multi-cycle ALU: 1-cycle latency for simple ops, WIDTH+1 for MUL/DIV/MOD.
// Accepts start only while ready (IDLE); results and flags hold until the next done pulse.
module alu_multiciclo
    import alu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic clk,
    input  logic rst_n,
    alu_multiciclo_if.slave bus
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           op_q, op_d;
    logic [WIDTH-1:0]     s_q, s_d;
    logic [2*WIDTH-1:0]   res_q, res_d;
    logic                 z_q, z_d, n_q, n_d, v_q, v_d, c_q, c_d, err_q, err_d;

    logic                 iter_load, iter_step, is_iter;
    md_mode_t             iter_mode;
    logic [WIDTH-1:0]     hi, lo, iter_s;

    logic [WIDTH:0]       sum, dif, shl_w, shr_w;
    logic [WIDTH-1:0]     sc_s;
    logic [2*WIDTH-1:0]   sc_res;
    logic                 sc_v, sc_c, sc_err, sc_div0;

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (iter_load),
        .mode  (iter_mode),
        .a     (bus.A),
        .b     (bus.B),
        .step  (iter_step),
        .hi    (hi),
        .lo    (lo)
    );

    // Single-cycle results straight from the request, used on the accepting edge.
    always_comb begin
        sum     = {1'b0, bus.A} + {1'b0, bus.B} + {{WIDTH{1'b0}}, bus.Cin};
        dif     = {1'b0, bus.A} - {1'b0, bus.B} - {{WIDTH{1'b0}}, bus.Cin};
        shl_w   = {1'b0, bus.A} << bus.B[SHW-1:0];
        shr_w   = {bus.A, 1'b0} >> bus.B[SHW-1:0];
        sc_s    = '0;
        sc_v    = 1'b0;
        sc_c    = 1'b0;
        sc_err  = 1'b0;
        sc_div0 = 1'b0;
        case (bus.op)
            OP_ADD: begin
                sc_s = sum[WIDTH-1:0];
                sc_c = sum[WIDTH];
                sc_v = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SUB: begin
                sc_s = dif[WIDTH-1:0];
                sc_c = dif[WIDTH];
                sc_v = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (dif[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_DIV, OP_MOD: begin
                sc_div0 = 1'b1;
                sc_err  = 1'b1;
                sc_s    = (bus.op == OP_DIV) ? {WIDTH{1'b1}} : bus.A;
            end
            OP_AND: sc_s = bus.A & bus.B;
            OP_OR:  sc_s = bus.A | bus.B;
            OP_XOR: sc_s = bus.A ^ bus.B;
            OP_SHL: begin
                sc_s = shl_w[WIDTH-1:0];
                sc_c = shl_w[WIDTH];
            end
            OP_SHR: begin
                sc_s = shr_w[WIDTH:1];
                sc_c = shr_w[0];
            end
            OP_NONE: sc_err = 1'b1;
            default: sc_err = 1'b1;
        endcase
        sc_res = sc_div0 ? {bus.A, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, sc_s};
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        s_d       = s_q;
        res_d     = res_q;
        z_d       = z_q;
        n_d       = n_q;
        v_d       = v_q;
        c_d       = c_q;
        err_d     = err_q;
        iter_load = 1'b0;
        iter_step = 1'b0;
        iter_mode = (bus.op == OP_MUL) ? MD_MUL : MD_DIV;
        is_iter   = (bus.op == OP_MUL) ||
                    (((bus.op == OP_DIV) || (bus.op == OP_MOD)) && (bus.B != '0));
        iter_s    = (op_q == OP_MOD) ? hi : lo;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d = bus.op;
                    if (is_iter) begin
                        iter_load = 1'b1;
                        cnt_d     = '0;
                        state_d   = ITER;
                    end else begin
                        s_d     = sc_s;
                        res_d   = sc_res;
                        z_d     = (sc_s == '0);
                        n_d     = sc_s[WIDTH-1];
                        v_d     = sc_v;
                        c_d     = sc_c;
                        err_d   = sc_err;
                        state_d = DONE;
                    end
                end
            end
            ITER: begin
                cnt_d     = cnt_q + CW'(1);
                iter_step = (cnt_q != LAST);
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    s_d     = iter_s;
                    res_d   = {hi, lo};
                    v_d     = 1'b0;
                    err_d   = 1'b0;
                    if (op_q == OP_MUL) begin
                        z_d = ({hi, lo} == '0);
                        n_d = hi[WIDTH-1];
                        c_d = (hi != '0);
                    end else begin
                        z_d = (iter_s == '0);
                        n_d = iter_s[WIDTH-1];
                        c_d = 1'b0;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            s_q     <= '0;
            res_q   <= '0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            v_q     <= 1'b0;
            c_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            s_q     <= s_d;
            res_q   <= res_d;
            z_q     <= z_d;
            n_q     <= n_d;
            v_q     <= v_d;
            c_q     <= c_d;
            err_q   <= err_d;
        end
    end

    assign bus.ready = (state_q == IDLE);
    assign bus.done  = (state_q == DONE);
    assign bus.S     = s_q;
    assign bus.res   = res_q;
    assign bus.Z     = z_q;
    assign bus.N     = n_q;
    assign bus.V     = v_q;
    assign bus.C     = c_q;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_alu_multiciclo.sv
// Directed vectors for the multi-cycle ALU, checked by a queue-based scoreboard and done-monitor.
module tb_alu_multiciclo;
    import alu_pkg::*;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_multiciclo_if #(.WIDTH(W)) bus ();

    alu_multiciclo #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string            name;
        logic [W-1:0]     s;
        logic [2*W-1:0]   res;
        logic [4:0]       flg;   // {Z,N,V,C,err}
        int               lat;
        int               acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("spurious done", {63'd0, bus.done}, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check({mon_e.name, " S"},   {60'd0, bus.S}, {60'd0, mon_e.s});
                    check({mon_e.name, " res"}, {56'd0, bus.res}, {56'd0, mon_e.res});
                    check({mon_e.name, " ZNVC.err"},
                          {59'd0, bus.Z, bus.N, bus.V, bus.C, bus.err}, {59'd0, mon_e.flg});
                    check({mon_e.name, " latency"}, 64'(cyc - mon_e.acc), 64'(mon_e.lat));
                end
            end
        end
    end

    task automatic wait_ready(input string nm);
        int guard = 0;
        @(negedge clk);
        while (bus.ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check({nm, " ready timeout"}, {63'd0, bus.ready}, 64'd1);
    endtask

    task automatic issue(input string nm, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic cin, input logic [W-1:0] es,
                         input logic [2*W-1:0] eres, input logic [4:0] eflg, input int lat);
        exp_t e;
        wait_ready(nm);
        bus.start = 1'b1;
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        bus.Cin   = cin;
        e.name = nm; e.s = es; e.res = eres; e.flg = eflg; e.lat = lat; e.acc = cyc;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = W'($urandom);
        bus.B     = W'($urandom);
        bus.Cin   = 1'($urandom);
    endtask

    task automatic check_cleared(input string nm);
        check({nm, " ready"}, {63'd0, bus.ready}, 64'd1);
        check({nm, " done"},  {63'd0, bus.done},  64'd0);
        check({nm, " S"},     {60'd0, bus.S},     64'd0);
        check({nm, " res"},   {56'd0, bus.res},   64'd0);
        check({nm, " flags"}, {59'd0, bus.Z, bus.N, bus.V, bus.C, bus.err}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        bus.op    = 4'h0;
        bus.A     = '0;
        bus.B     = '0;
        bus.Cin   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_cleared("reset");
        rst_n = 1'b1;

        //     name        op      A      B      Cin   S      res     ZNVCE      lat
        issue("add 7+9",   OP_ADD, 4'h7, 4'h9, 1'b0, 4'h0, 8'h00, 5'b10010, 1);
        issue("sub 3-5",   OP_SUB, 4'h3, 4'h5, 1'b0, 4'hE, 8'h0E, 5'b01010, 1);
        issue("add 7+1",   OP_ADD, 4'h7, 4'h1, 1'b0, 4'h8, 8'h08, 5'b01100, 1);
        issue("add f+1+c", OP_ADD, 4'hF, 4'h1, 1'b1, 4'h1, 8'h01, 5'b00010, 1);
        issue("sub 8-1",   OP_SUB, 4'h8, 4'h1, 1'b0, 4'h7, 8'h07, 5'b00100, 1);
        issue("sub 5-5-c", OP_SUB, 4'h5, 4'h5, 1'b1, 4'hF, 8'h0F, 5'b01010, 1);
        issue("mul 13*11", OP_MUL, 4'hD, 4'hB, 1'b0, 4'hF, 8'h8F, 5'b01010, 5);
        issue("mul 3*2",   OP_MUL, 4'h3, 4'h2, 1'b0, 4'h6, 8'h06, 5'b00000, 5);
        issue("mul 0*9",   OP_MUL, 4'h0, 4'h9, 1'b0, 4'h0, 8'h00, 5'b10000, 5);
        issue("div 13/4",  OP_DIV, 4'hD, 4'h4, 1'b0, 4'h3, 8'h13, 5'b00000, 5);
        issue("mod 13%4",  OP_MOD, 4'hD, 4'h4, 1'b0, 4'h1, 8'h13, 5'b00000, 5);
        issue("div 15/3",  OP_DIV, 4'hF, 4'h3, 1'b0, 4'h5, 8'h05, 5'b00000, 5);
        issue("div 2/7",   OP_DIV, 4'h2, 4'h7, 1'b0, 4'h0, 8'h20, 5'b10000, 5);
        issue("div 9/0",   OP_DIV, 4'h9, 4'h0, 1'b0, 4'hF, 8'h9F, 5'b01001, 1);
        issue("mod 9%0",   OP_MOD, 4'h9, 4'h0, 1'b0, 4'h9, 8'h9F, 5'b01001, 1);
        issue("and",       OP_AND, 4'hC, 4'hA, 1'b0, 4'h8, 8'h08, 5'b01000, 1);
        issue("or",        OP_OR,  4'h5, 4'h2, 1'b0, 4'h7, 8'h07, 5'b00000, 1);
        issue("xor",       OP_XOR, 4'hF, 4'hF, 1'b0, 4'h0, 8'h00, 5'b10000, 1);
        issue("shl 6<<2",  OP_SHL, 4'h6, 4'h2, 1'b0, 4'h8, 8'h08, 5'b01010, 1);
        issue("shr 5>>1",  OP_SHR, 4'h5, 4'h1, 1'b0, 4'h2, 8'h02, 5'b00010, 1);
        issue("shl b<<0",  OP_SHL, 4'hB, 4'h0, 1'b0, 4'hB, 8'h0B, 5'b01000, 1);
        issue("shr 8>>3",  OP_SHR, 4'h8, 4'h3, 1'b0, 4'h1, 8'h01, 5'b00000, 1);
        issue("shl 1<<3",  OP_SHL, 4'h1, 4'h3, 1'b0, 4'h8, 8'h08, 5'b01000, 1);
        issue("shl 9<<1",  OP_SHL, 4'h9, 4'h1, 1'b0, 4'h2, 8'h02, 5'b00010, 1);
        issue("illegal f", 4'hF,   4'h3, 4'h4, 1'b0, 4'h0, 8'h00, 5'b10001, 1);
        issue("illegal 0", 4'h0,   4'h6, 4'h1, 1'b1, 4'h0, 8'h00, 5'b10001, 1);

        // start raised during ITER must be ignored; ready stays low through ITER and DONE
        issue("mul 15*15", OP_MUL, 4'hF, 4'hF, 1'b0, 4'h1, 8'hE1, 5'b01010, 5);
        check("busy ready c1", {63'd0, bus.ready}, 64'd0);
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("busy ready c%0d", k), {63'd0, bus.ready}, 64'd0);
            if (k == 2) begin
                bus.start = 1'b1;
                bus.op    = OP_ADD;
                bus.A     = 4'h7;
                bus.B     = 4'h9;
            end else begin
                bus.start = 1'b0;
            end
        end

        // reset in the middle of a multiply: no done, everything cleared
        wait_ready("abort");
        bus.start = 1'b1;
        bus.op    = OP_MUL;
        bus.A     = 4'h5;
        bus.B     = 4'h3;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_cleared("abort");
        repeat (8) @(negedge clk);

        issue("add 2+3",   OP_ADD, 4'h2, 4'h3, 1'b0, 4'h5, 8'h05, 5'b00000, 1);

        for (int g = 0; g < 50 && sb.size() != 0; g++) @(negedge clk);
        check("scoreboard drained", 64'(sb.size()), 64'd0);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
